// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_arbiter
// Description : Shares the register file's single write port between two
//               writeback requesters (req0 = ALU, req1 = load). Each
//               requester owns a one-entry holding buffer behind a
//               valid/ready handshake. Contested grants alternate
//               round-robin, except that two buffered writes to the same
//               register always retire oldest-first. A per-register
//               pending mask lets decode stall reads of registers whose
//               writes are still in flight.
// Ports       : clock, reset            - clock, synchronous active-high reset
//               reqN_valid/ready        - handshake for requester N
//               reqN_reg/reqN_data      - destination register / write data
//               RegWrite/write_reg/
//               write_data              - registered register-file write port
//               grant_id                - requester on the port (when RegWrite)
//               pending                 - bit r set while a write to r is
//                                         buffered or on the port
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic [ADDR_WIDTH-1:0]    req0_reg,
    input  logic [DATA_WIDTH-1:0]    req0_data,
    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic [ADDR_WIDTH-1:0]    req1_reg,
    input  logic [DATA_WIDTH-1:0]    req1_data,
    output logic                     RegWrite,
    output logic [ADDR_WIDTH-1:0]    write_reg,
    output logic [DATA_WIDTH-1:0]    write_data,
    output logic                     grant_id,
    output logic [2**ADDR_WIDTH-1:0] pending
);

    localparam int c_NUM_REGS = 2**ADDR_WIDTH;

    // Holding buffers
    logic                  r_buf0_full;
    logic [ADDR_WIDTH-1:0] r_buf0_reg;
    logic [DATA_WIDTH-1:0] r_buf0_data;
    logic                  r_buf1_full;
    logic [ADDR_WIDTH-1:0] r_buf1_reg;
    logic [DATA_WIDTH-1:0] r_buf1_data;

    // Round-robin pointer: requester favoured on the next contested grant
    logic r_ptr;
    // Set when buf1's entry was loaded strictly before buf0's entry
    logic r_buf1_older;

    logic w_same_reg;
    logic w_contested;
    logic w_grant0;
    logic w_grant1;
    logic w_acc0;
    logic w_acc1;

    assign w_same_reg  = (r_buf0_reg == r_buf1_reg);
    assign w_contested = r_buf0_full && r_buf1_full && !w_same_reg;

    // buf0 wins when alone, when it holds the older same-register write, or
    // when the pointer favours it for different registers.
    assign w_grant0 = r_buf0_full &&
                      (!r_buf1_full ||
                       (w_same_reg ? !r_buf1_older : !r_ptr));
    assign w_grant1 = r_buf1_full && !w_grant0;

    // A buffer being drained this edge can take a new entry on the same edge.
    assign req0_ready = !reset && (!r_buf0_full || w_grant0);
    assign req1_ready = !reset && (!r_buf1_full || w_grant1);

    assign w_acc0 = req0_valid && req0_ready;
    assign w_acc1 = req1_valid && req1_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_buf0_full  <= 1'b0;
            r_buf0_reg   <= '0;
            r_buf0_data  <= '0;
            r_buf1_full  <= 1'b0;
            r_buf1_reg   <= '0;
            r_buf1_data  <= '0;
            r_ptr        <= 1'b0;
            r_buf1_older <= 1'b0;
            RegWrite     <= 1'b0;
            write_reg    <= '0;
            write_data   <= '0;
            grant_id     <= 1'b0;
        end else begin
            if (w_acc0) begin
                r_buf0_full <= 1'b1;
                r_buf0_reg  <= req0_reg;
                r_buf0_data <= req0_data;
            end else if (w_grant0) begin
                r_buf0_full <= 1'b0;
            end

            if (w_acc1) begin
                r_buf1_full <= 1'b1;
                r_buf1_reg  <= req1_reg;
                r_buf1_data <= req1_data;
            end else if (w_grant1) begin
                r_buf1_full <= 1'b0;
            end

            // The newly loaded entry is always the younger one; on a
            // same-edge double load req0 counts as older.
            if (w_acc0 && w_acc1) begin
                r_buf1_older <= 1'b0;
            end else if (w_acc0) begin
                r_buf1_older <= 1'b1;
            end else if (w_acc1) begin
                r_buf1_older <= 1'b0;
            end

            // Only a round-robin decision moves the pointer.
            if (w_contested) begin
                r_ptr <= w_grant0;
            end

            RegWrite <= w_grant0 || w_grant1;
            if (w_grant0) begin
                write_reg  <= r_buf0_reg;
                write_data <= r_buf0_data;
                grant_id   <= 1'b0;
            end else if (w_grant1) begin
                write_reg  <= r_buf1_reg;
                write_data <= r_buf1_data;
                grant_id   <= 1'b1;
            end
        end
    end

    for (genvar r = 0; r < c_NUM_REGS; r++) begin : g_pending
        assign pending[r] = (r_buf0_full && (r_buf0_reg == ADDR_WIDTH'(r))) ||
                            (r_buf1_full && (r_buf1_reg == ADDR_WIDTH'(r))) ||
                            (RegWrite    && (write_reg  == ADDR_WIDTH'(r)));
    end

endmodule
`default_nettype wire
